// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU memory-bus fabric.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  localparam int SLV_ROM  = 0;
  localparam int SLV_WRAM = 1;
  localparam int SLV_VRAM = 2;
  localparam int SLV_LED  = 3;
  localparam int SLV_UART = 4;
  localparam int SLV_ENC  = 5;
  localparam int SLV_PRNG = 6;
endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating stall counter; expired goes high once TIMEOUT cycles have been counted.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign expired = (wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || clr)
      wait_cnt <= '0;
    else if (en && !expired)
      wait_cnt <= wait_cnt + 1'b1;
  end
endmodule

// File: rtl/mem_bus_fabric.sv
// picorv32 native-bus interconnect: address decode, ready/rdata return,
// stall watchdog and sticky error logging for N slave windows.
module mem_bus_fabric
  import bus_pkg::*;
#(
  parameter int                    NUM_SLAVES = 8,
  parameter int                    SEL_HI     = 15,
  parameter int                    SEL_LO     = 12,
  parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = 8'h0F,
  parameter int                    TIMEOUT    = 255,
  parameter logic [31:0]           ERR_DATA   = DEFAULT_ERR_DATA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  output logic                       bus_err,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;

  state_t                 state, nstate;
  logic [SEL_W-1:0]       idx;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   mapped, sync_hit, rdy_hit;
  logic [31:0]            rdata_mux;
  logic                   done, err, cnt_clr, cnt_en, expired;
  logic                   unused_addr;

  assign idx         = mem_addr[SEL_HI:SEL_LO];
  assign unused_addr = ^mem_addr[SEL_LO-1:0];

  // One-hot decode; idx values beyond NUM_SLAVES simply produce no hit.
  always_comb begin
    hit       = '0;
    rdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (idx == SEL_W'(i));
      if (hit[i]) rdata_mux = s_rdata[32*i +: 32];
    end
  end

  assign mapped   = (|hit) && (mem_addr[31:SEL_HI+1] == '0);
  assign sync_hit = |(hit & SYNC_MASK);
  assign rdy_hit  = |(hit & s_ready & ~SYNC_MASK);

  assign s_sel   = (mapped && mem_valid && state != RECOVER && !rst) ? hit : '0;
  assign s_wstrb = (|s_sel) ? mem_wstrb : 4'h0;

  always_comb begin
    nstate  = state;
    done    = 1'b0;
    err     = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state)
      IDLE:
        if (mem_valid) begin
          if (!mapped) begin
            done = 1'b1; err = 1'b1; nstate = RECOVER;
          end else if (!sync_hit && rdy_hit) begin
            done = 1'b1; nstate = RECOVER;
          end else begin
            nstate = BUSY; cnt_clr = 1'b0; cnt_en = 1'b1;
          end
        end
      BUSY:
        if (!mem_valid) begin
          nstate = IDLE;
        end else if (sync_hit || rdy_hit) begin
          done = 1'b1; nstate = RECOVER;
        end else if (expired) begin
          done = 1'b1; err = 1'b1; nstate = RECOVER;
        end else begin
          cnt_clr = 1'b0; cnt_en = 1'b1;
        end
      RECOVER: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  assign mem_ready = done && !rst;
  assign mem_rdata = !mem_ready ? 32'h0 : (err ? ERR_DATA : rdata_mux);

  // A new error outranks a simultaneous clear and re-arms the first-error address.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (mem_ready && err) begin
      bus_err <= 1'b1;
      if (!bus_err || err_clr) err_addr <= mem_addr;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end
  end
endmodule

// File: tb/tb_mem_bus_fabric.sv
// Transaction-level bench for mem_bus_fabric with 7 slaves and an 8-cycle watchdog.
module tb_mem_bus_fabric;
  localparam int          N  = 7;
  localparam int          TO = 8;
  localparam logic [N-1:0] SM = 7'h0F;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_valid;
  logic [31:0]    mem_addr;
  logic [3:0]     mem_wstrb;
  logic           mem_ready;
  logic [31:0]    mem_rdata;
  logic [N-1:0]   s_sel;
  logic [3:0]     s_wstrb;
  logic [N-1:0]   s_ready;
  logic [32*N-1:0] s_rdata;
  logic           bus_err;
  logic [31:0]    err_addr;
  logic           err_clr;

  int checks = 0;
  int errors = 0;
  logic        m_err;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  mem_bus_fabric #(.NUM_SLAVES(N), .SYNC_MASK(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .s_sel(s_sel), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    mem_valid = 1'b0; mem_wstrb = 4'h0; err_clr = 1'b0; s_ready = N'($urandom);
    @(negedge clk);
    chk("idle_ready", 32'(mem_ready), 0);
    chk("idle_sel",   32'(s_sel), 0);
    chk("idle_rdata", mem_rdata, 0);
    chk("idle_err",   32'(bus_err), 32'(m_err));
    chk("idle_eaddr", err_addr, m_addr);
    @(posedge clk); #1;
  endtask

  // d: cycle at which an async slave raises ready (d > TO means never).
  // clr_k: cycle at which err_clr is pulsed (-1 means never).
  task automatic txn(input logic [31:0] a, input logic [3:0] ws, input int d, input int clr_k);
    int idx, lat;
    bit mapped, sync, err;
    logic [N-1:0] oh;
    logic [31:0] rd;
    string tg;
    idx    = int'(a[15:12]);
    mapped = (idx < N) && (a[31:16] == 16'h0);
    sync   = 1'b0;
    oh     = '0;
    if (mapped) begin
      sync = SM[idx];
      oh   = N'(1) << idx;
    end
    if (!mapped)     begin lat = 0;  err = 1'b1; end
    else if (sync)   begin lat = 1;  err = 1'b0; end
    else if (d <= TO) begin lat = d; err = 1'b0; end
    else             begin lat = TO; err = 1'b1; end
    for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = $urandom;
    rd = err ? ED : s_rdata[32*idx +: 32];
    for (int k = 0; k <= lat + 1; k++) begin
      mem_valid = 1'b1; mem_addr = a; mem_wstrb = ws; err_clr = (k == clr_k);
      s_ready = N'($urandom);
      if (mapped && !sync) s_ready = (k >= d) ? (s_ready | oh) : (s_ready & ~oh);
      @(negedge clk);
      tg = $sformatf("a=%h k=%0d", a, k);
      chk({"sel ", tg},     32'(s_sel), (k <= lat) ? 32'(oh) : 0);
      chk({"wstrb ", tg},   32'(s_wstrb), (k <= lat && mapped) ? 32'(ws) : 0);
      chk({"ready ", tg},   32'(mem_ready), 32'(k == lat));
      chk({"rdata ", tg},   mem_rdata, (k == lat) ? rd : 0);
      chk({"bus_err ", tg}, 32'(bus_err), 32'(m_err));
      chk({"err_addr ", tg}, err_addr, m_addr);
      if (k == lat && err) begin
        if (!m_err || k == clr_k) m_addr = a;
        m_err = 1'b1;
      end else if (k == clr_k) begin
        m_err = 1'b0; m_addr = 0;
      end
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
    idle_cycle();
  endtask

  // Stall an async slave for a few cycles then drop mem_valid.
  task automatic abort_txn(input logic [31:0] a, input int cycles);
    logic [N-1:0] oh;
    oh = N'(1) << int'(a[15:12]);
    for (int k = 0; k < cycles; k++) begin
      mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'h0;
      s_ready = N'($urandom) & ~oh;
      @(negedge clk);
      chk("abort_ready", 32'(mem_ready), 0);
      chk("abort_sel",   32'(s_sel), 32'(oh));
      @(posedge clk); #1;
    end
    idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] a, up, off;
    int sel, d, ck;
    rst = 1'b1; mem_valid = 1'b0; mem_addr = 0; mem_wstrb = 0;
    s_ready = '0; s_rdata = '0; err_clr = 1'b0;
    m_err = 1'b0; m_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_err",   32'(bus_err), 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_sel",   32'(s_sel), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    txn(32'h0000_1004, 4'h0, 0, -1);   // sync read, one-cycle ready
    txn(32'h0000_4000, 4'h1, 3, -1);   // async write, ready at cycle 3
    txn(32'h0000_7000, 4'h0, 0, -1);   // unmapped index
    txn(32'h0000_5000, 4'h0, 99, -1);  // timeout, first error address kept
    txn(32'h0001_0000, 4'h0, 0, 0);    // error and clear together
    txn(32'h0000_6000, 4'hF, TO, -1);  // ready exactly at the timeout cycle
    txn(32'h0000_4010, 4'h0, 0, -1);   // zero-wait async
    txn(32'h0000_2000, 4'h3, 5, 1);    // clear with no error
    txn(32'h8000_0000, 4'hF, 0, -1);   // upper address bits set, write
    abort_txn(32'h0000_5000, 3);
    txn(32'h0000_5000, 4'h0, 99, -1);  // full timeout after an abort

    // Reset while BUSY on a hung slave.
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_addr = 32'h0000_6000; s_ready = '0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_ready", 32'(mem_ready), 0);
    chk("rstbusy_sel",   32'(s_sel), 0);
    @(posedge clk); #1;
    rst = 1'b0; m_err = 1'b0; m_addr = 0;
    idle_cycle();
    txn(32'h0000_0000, 4'h0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      up  = ($urandom_range(0, 7) == 0) ? {16'($urandom | 1), 16'h0} : 32'h0;
      off = 32'($urandom_range(0, 4095));
      a   = up | (32'(sel) << 12) | off;
      d   = $urandom_range(0, TO + 3);
      ck  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      txn(a, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), d, ck);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_fabric.md
Name: mem_bus_fabric

Overview:
- Parametrised N-slave interconnect between the picorv32 native memory bus and the SoC peripherals.
- Replaces hand-written chip-select, ready-OR and rdata-mux logic with one decoder and one ready/data return path.
- Adds per-slave ready mode (fixed registered or slave-driven), a timeout watchdog, and error responses for unmapped or hung accesses.
- Guarantees exactly one mem_ready per transaction.

Parameters:
- NUM_SLAVES, 8: number of slave windows; slave i owns select value i.
- SEL_HI, 15: MSB of the address select field.
- SEL_LO, 12: LSB of the address select field; window size is 2^SEL_LO bytes.
- SYNC_MASK, 8'h0F: bit i=1 means slave i is fixed-latency; the fabric generates its ready one cycle after select, and s_ready[i] is ignored.
- TIMEOUT, 255: cycles an async slave may stall before the fabric forces an error completion; 8..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on any error completion.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  CPU byte address
- mem_wstrb  in  4  CPU write strobes; 0 means read
- mem_ready  out  1  transaction complete (one-cycle pulse)
- mem_rdata  out  32  read data, valid while mem_ready=1
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_wstrb  out  4  mem_wstrb gated by s_sel; 0 when no slave is selected
- s_ready  in  NUM_SLAVES  per-slave ready; used only where the SYNC_MASK bit is 0
- s_rdata  in  32*NUM_SLAVES  slave i read data on bits [32i+31:32i]
- bus_err  out  1  sticky error flag
- err_addr  out  32  address of the first error since the last clear
- err_clr  in  1  clears bus_err and err_addr

Behaviour:
- Reset values: state=IDLE, mem_ready=0, bus_err=0, err_addr=0, wait_cnt=0. s_sel=0 because the state is not BUSY-eligible in reset.
- idx = mem_addr[SEL_HI:SEL_LO]. The access is unmapped if idx >= NUM_SLAVES or any address bit above SEL_HI is nonzero.
- s_sel[idx] = mem_valid & mapped & (state != RECOVER). It is combinational, so the slave sees the select in the same cycle as valid.
- States: IDLE, BUSY, RECOVER.
- IDLE:
  - mem_valid=1 and unmapped: mem_ready=1 the same cycle, mem_rdata=ERR_DATA, error logged, next state RECOVER.
  - Mapped async slave with s_ready[idx]=1: mem_ready=1 the same cycle, next state RECOVER.
  - Otherwise, for a mapped access: next state BUSY, wait_cnt=1.
- BUSY:
  - Sync slave: mem_ready=1 (exactly one cycle after entry), next state RECOVER.
  - Async slave with s_ready[idx]=1: mem_ready=1, next state RECOVER.
  - Async slave stalled with wait_cnt==TIMEOUT: mem_ready=1, mem_rdata=ERR_DATA, error logged, next state RECOVER.
  - Otherwise wait_cnt increments.
  - If mem_valid drops in BUSY (abort): return to IDLE with no ready pulse.
- RECOVER: lasts one cycle. s_sel=0, s_ready ignored, mem_ready=0, next state IDLE. This blocks a double acknowledge if the CPU holds mem_valid.
- mem_rdata is muxed from s_rdata[idx] whenever mem_ready=1 and there is no error; it is 0 when mem_ready=0.
- Writes:
  - Writes to unmapped addresses never assert any s_sel.
  - Timed-out writes still completed at the slave side are the slave's responsibility; the fabric only drops the select.
- Error logging:
  - bus_err is set on the error-completion cycle.
  - err_addr is captured only if bus_err was 0, so the first error wins.
  - err_clr=1 clears both fields the next cycle. If err_clr and a new error occur in the same cycle, the error wins: bus_err=1 and err_addr=new address.
- Reset asserted mid-transaction returns to IDLE with no ready pulse.
- wait_cnt saturates and is sized ceil(log2(TIMEOUT+1)) bits.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, BUSY, RECOVER}
  - DEFAULT_ERR_DATA
  - SoC slave index constants (ROM=0, WRAM=1, VRAM=2, LED=3, UART=4, ENC=5, PRNG=6)
- One sub-module, bus_timeout_counter: clear/enable/expired, parametrised by TIMEOUT.
- The decode and mux stay in mem_bus_fabric.

Test Plan:
1. Read 0x0000_1004 (sync slave 1, s_rdata[63:32]=32'h1234_5678) with mem_valid held 3 cycles -> s_sel=8'h02 in cycle 0; mem_ready=1 only in cycle 1 with rdata 32'h1234_5678; no second pulse in cycle 2.
2. Write 0x0000_4000 (async UART, wstrb 4'h1), s_ready[4] raised in cycle 3 -> s_wstrb=4'h1 while selected; mem_ready=1 in cycle 3 only; bus_err stays 0.
3. Read 0x0000_7000 with NUM_SLAVES=7 -> mem_ready=1 in cycle 0, rdata 32'hDEAD_BEEF, s_sel=0, bus_err=1, err_addr=0x0000_7000.
4. Async slave 5 never ready, TIMEOUT=8 -> mem_ready=1 exactly at cycle 8 with ERR_DATA; err_addr unchanged if bus_err was already set.
5. err_clr pulsed in the same cycle as an access to 0x0001_0000 -> bus_err=1, err_addr=0x0001_0000.
6. rst=1 while in BUSY -> next cycle state IDLE, mem_ready=0, s_sel=0, bus_err=0.
